// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic REQ_DCACHE = 1'b0;
  localparam logic REQ_ICACHE = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 256;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, memory and (with ARB_PERF_CNT_EN) performance-counter signals of dmem_arbiter.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
`ifdef ARB_PERF_CNT_EN
  , parameter int CNT_W = DEF_CNT_W
`endif
);
  logic              req0_enable_i;
  logic              req0_write_i;
  logic [ADDR_W-1:0] req0_addr_i;
  logic [DATA_W-1:0] req0_data_i;
  logic              req0_ack_o;
  logic [DATA_W-1:0] req0_data_o;

  logic              req1_enable_i;
  logic              req1_write_i;
  logic [ADDR_W-1:0] req1_addr_i;
  logic [DATA_W-1:0] req1_data_i;
  logic              req1_ack_o;
  logic [DATA_W-1:0] req1_data_o;

  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_data_i;

`ifdef ARB_PERF_CNT_EN
  logic [CNT_W-1:0]  perf_grant0_o;
  logic [CNT_W-1:0]  perf_grant1_o;
  logic [CNT_W-1:0]  perf_conflict_o;
  logic [CNT_W-1:0]  perf_wait0_o;
  logic [CNT_W-1:0]  perf_wait1_o;
`endif

  modport slave (
    input  req0_enable_i, req0_write_i, req0_addr_i, req0_data_i,
    input  req1_enable_i, req1_write_i, req1_addr_i, req1_data_i,
    input  mem_ack_i, mem_data_i,
    output req0_ack_o, req0_data_o, req1_ack_o, req1_data_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
`ifdef ARB_PERF_CNT_EN
    , output perf_grant0_o, perf_grant1_o, perf_conflict_o, perf_wait0_o, perf_wait1_o
`endif
  );

  modport master (
    output req0_enable_i, req0_write_i, req0_addr_i, req0_data_i,
    output req1_enable_i, req1_write_i, req1_addr_i, req1_data_i,
    output mem_ack_i, mem_data_i,
    input  req0_ack_o, req0_data_o, req1_ack_o, req1_data_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
`ifdef ARB_PERF_CNT_EN
    , input perf_grant0_o, perf_grant1_o, perf_conflict_o, perf_wait0_o, perf_wait1_o
`endif
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick: on a tie the requester not granted last time wins.
module rr_pick2 (
  input  logic en0,
  input  logic en1,
  input  logic last_grant,
  output logic any,
  output logic pick
);

  assign any  = en0 | en1;
  assign pick = (en0 && en1) ? ~last_grant : en1;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter of the L1 D-cache (req0) and I-cache (req1) onto one line memory,
// one transaction in flight. Define ARB_PERF_CNT_EN to add saturating performance counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
`ifdef ARB_PERF_CNT_EN
  , parameter int CNT_W = DEF_CNT_W
`endif
) (
  input logic          clk_i,
  input logic          rst_i,
  dmem_arbiter_if.slave bus
);

  arb_state_e        state;
  arb_state_e        nxt;
  logic              owner;
  logic              last_grant;
  logic [DATA_W-1:0] hold0;
  logic [DATA_W-1:0] hold1;

  logic              req_any;
  logic              pick;
  logic              grant;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_ad;
  logic [DATA_W-1:0] mem_dt;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rd0;
  logic [DATA_W-1:0] rd1;

  rr_pick2 u_pick (
    .en0        (bus.req0_enable_i),
    .en1        (bus.req1_enable_i),
    .last_grant (last_grant),
    .any        (req_any),
    .pick       (pick)
  );

  assign grant = (state == IDLE) && req_any;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      owner      <= REQ_DCACHE;
      last_grant <= REQ_ICACHE;
      hold0      <= '0;
      hold1      <= '0;
    end else begin
      state <= nxt;
      if (grant) begin
        owner      <= pick;
        last_grant <= pick;
      end
      // The returned line is only valid during RESP; keep it for the owner afterwards.
      if (state == RESP) begin
        if (owner == REQ_DCACHE) hold0 <= bus.mem_data_i;
        else                     hold1 <= bus.mem_data_i;
      end
    end
  end

  always_comb begin
    nxt    = state;
    mem_en = 1'b0;
    mem_wr = 1'b0;
    mem_ad = '0;
    mem_dt = '0;
    ack0   = 1'b0;
    ack1   = 1'b0;
    rd0    = hold0;
    rd1    = hold1;
    case (state)
      IDLE:  if (req_any) nxt = ISSUE;
      ISSUE: begin
        mem_en = 1'b1;
        nxt    = WAIT;
      end
      WAIT:  if (bus.mem_ack_i) nxt = RESP;
      RESP: begin
        nxt = IDLE;
        if (owner == REQ_DCACHE) begin
          ack0 = 1'b1;
          rd0  = bus.mem_data_i;
        end else begin
          ack1 = 1'b1;
          rd1  = bus.mem_data_i;
        end
      end
      default: nxt = IDLE;
    endcase
    if (state == ISSUE || state == WAIT) begin
      if (owner == REQ_ICACHE) begin
        mem_wr = bus.req1_write_i;
        mem_ad = bus.req1_addr_i;
        mem_dt = bus.req1_data_i;
      end else begin
        mem_wr = bus.req0_write_i;
        mem_ad = bus.req0_addr_i;
        mem_dt = bus.req0_data_i;
      end
    end
  end

  assign bus.mem_enable_o = mem_en;
  assign bus.mem_write_o  = mem_wr;
  assign bus.mem_addr_o   = mem_ad;
  assign bus.mem_data_o   = mem_dt;
  assign bus.req0_ack_o   = ack0;
  assign bus.req1_ack_o   = ack1;
  assign bus.req0_data_o  = rd0;
  assign bus.req1_data_o  = rd1;

`ifdef ARB_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_g0;
  logic [CNT_W-1:0] cnt_g1;
  logic [CNT_W-1:0] cnt_conf;
  logic [CNT_W-1:0] cnt_w0;
  logic [CNT_W-1:0] cnt_w1;
  logic             served0;
  logic             served1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  assign served0 = (state == RESP) && (owner == REQ_DCACHE);
  assign served1 = (state == RESP) && (owner == REQ_ICACHE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_g0   <= '0;
      cnt_g1   <= '0;
      cnt_conf <= '0;
      cnt_w0   <= '0;
      cnt_w1   <= '0;
    end else begin
      cnt_g0   <= sat_inc(cnt_g0, grant && (pick == REQ_DCACHE));
      cnt_g1   <= sat_inc(cnt_g1, grant && (pick == REQ_ICACHE));
      cnt_conf <= sat_inc(cnt_conf, (state == IDLE) && bus.req0_enable_i && bus.req1_enable_i);
      cnt_w0   <= sat_inc(cnt_w0, bus.req0_enable_i && !served0);
      cnt_w1   <= sat_inc(cnt_w1, bus.req1_enable_i && !served1);
    end
  end

  assign bus.perf_grant0_o   = cnt_g0;
  assign bus.perf_grant1_o   = cnt_g1;
  assign bus.perf_conflict_o = cnt_conf;
  assign bus.perf_wait0_o    = cnt_w0;
  assign bus.perf_wait1_o    = cnt_w1;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 7-cycle-wait line memory model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam logic [DW-1:0] LINE_A = {8{32'hA5A5_0040}};
  localparam logic [DW-1:0] LINE_B = {8{32'h0B0B_0080}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stray = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: ack in the 7th cycle after the issue cycle, read line valid the cycle after ack.
  logic [DW-1:0] mem [0:127];
  logic          mack;
  logic [DW-1:0] mrd;
  int            dly;
  logic          lat_w;
  logic [AW-1:0] lat_a;
  logic [DW-1:0] lat_d;

  always @(posedge clk) begin
    if (rst) begin
      mack   <= 1'b0;
      dly    <= 0;
      mrd    <= '0;
      mem[2] <= LINE_A;
    end else begin
      mack <= 1'b0;
      if (bus.mem_enable_o) begin
        dly   <= 6;
        lat_w <= bus.mem_write_o;
        lat_a <= bus.mem_addr_o;
        lat_d <= bus.mem_data_o;
      end else if (dly == 1) begin
        mack <= 1'b1;
        dly  <= 0;
      end else if (dly > 1) begin
        dly <= dly - 1;
      end
      if (mack) begin
        if (lat_w) mem[lat_a[11:5]] <= lat_d;
        else       mrd <= mem[lat_a[11:5]];
      end
    end
  end

  assign bus.mem_ack_i  = mack | stray;
  assign bus.mem_data_i = mrd;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".mem_en"}, bus.mem_enable_o, 0);
    chk({tag, ".mem_wr"}, bus.mem_write_o, 0);
    chk({tag, ".mem_addr"}, bus.mem_addr_o, 0);
    chk({tag, ".mem_data"}, bus.mem_data_o, 0);
    chk({tag, ".ack0"}, bus.req0_ack_o, 0);
    chk({tag, ".ack1"}, bus.req1_ack_o, 0);
  endtask

  task automatic set_req(input bit id, input bit en, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    if (id == 1'b0) begin
      bus.req0_write_i = wr; bus.req0_addr_i = a; bus.req0_data_i = d; bus.req0_enable_i = en;
    end else begin
      bus.req1_write_i = wr; bus.req1_addr_i = a; bus.req1_data_i = d; bus.req1_enable_i = en;
    end
  endtask

  // One lone transaction; request presented in cycle 0, expected ack in cycle 9.
  task automatic txn(input bit id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input bit chk_rd, input logic [DW-1:0] exp_rd, input string tag);
    logic own_ack;
    logic oth_ack;
    logic [DW-1:0] own_rd;
    set_req(id, 1'b1, wr, a, wd);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      own_ack = id ? bus.req1_ack_o : bus.req0_ack_o;
      oth_ack = id ? bus.req0_ack_o : bus.req1_ack_o;
      own_rd  = id ? bus.req1_data_o : bus.req0_data_o;
      chk($sformatf("%s.mem_en@%0d", tag, c), bus.mem_enable_o, (c == 1));
      chk($sformatf("%s.ack@%0d", tag, c), own_ack, (c == 9));
      chk($sformatf("%s.other_ack@%0d", tag, c), oth_ack, 0);
      if (c == 1) begin
        chk({tag, ".mem_wr"}, bus.mem_write_o, wr);
        chk({tag, ".mem_addr"}, bus.mem_addr_o, a);
        if (wr) chk({tag, ".mem_data"}, bus.mem_data_o, wd);
      end
      if (c == 9) begin
        if (chk_rd) chk({tag, ".rdata"}, own_rd, exp_rd);
        set_req(id, 1'b0, wr, a, wd);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int grants[$];
    bit saw_ack;

    bus.req0_enable_i = 0; bus.req0_write_i = 0; bus.req0_addr_i = '0; bus.req0_data_i = '0;
    bus.req1_enable_i = 0; bus.req1_write_i = 0; bus.req1_addr_i = '0; bus.req1_data_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    chk("reset.data0", bus.req0_data_o, 0);
    chk("reset.data1", bus.req1_data_o, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single read by req0, then the held data
    @(posedge clk); #1;
    txn(1'b0, 1'b0, 32'h40, '0, 1'b1, LINE_A, "rd0");
    repeat (3) @(negedge clk);
    chk("rd0.hold", bus.req0_data_o, LINE_A);
    chk("rd0.idle_en", bus.mem_enable_o, 0);

    // Write then read by req1
    @(posedge clk); #1;
    txn(1'b1, 1'b1, 32'h80, LINE_B, 1'b0, '0, "wr1");
    @(posedge clk); #1;
    txn(1'b1, 1'b0, 32'h80, '0, 1'b1, LINE_B, "rd1");

    // Simultaneous request right after reset: req0 first
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 32'h40, '0);
    set_req(1'b1, 1'b1, 1'b0, 32'h80, '0);
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      chk($sformatf("sim.mem_en@%0d", c), bus.mem_enable_o, (c == 1 || c == 11));
      chk($sformatf("sim.ack0@%0d", c), bus.req0_ack_o, (c == 9));
      chk($sformatf("sim.ack1@%0d", c), bus.req1_ack_o, (c == 19));
      if (c == 1)  chk("sim.addr_first", bus.mem_addr_o, 32'h40);
      if (c == 11) chk("sim.addr_second", bus.mem_addr_o, 32'h80);
      if (c == 9) begin
        chk("sim.rdata0", bus.req0_data_o, LINE_A);
        bus.req0_enable_i = 1'b0;
      end
      if (c == 19) begin
        chk("sim.rdata1", bus.req1_data_o, LINE_B);
        bus.req1_enable_i = 1'b0;
      end
    end

    // Sustained contention: both held, grants must alternate starting with req0
    @(posedge clk); #1;
    bus.req0_enable_i = 1'b1;
    bus.req1_enable_i = 1'b1;
    for (int c = 0; c < 100 && grants.size() < 6; c++) begin
      @(negedge clk);
      if (bus.req0_ack_o) grants.push_back(0);
      if (bus.req1_ack_o) grants.push_back(1);
    end
    bus.req0_enable_i = 1'b0;
    bus.req1_enable_i = 1'b0;
    chk("sus.count", grants.size(), 6);
    for (int k = 0; k < grants.size(); k++)
      chk($sformatf("sus.grant%0d", k), grants[k], k % 2);

    // Stray memory ack while idle
    repeat (2) @(posedge clk);
    #1 stray = 1'b1;
    @(negedge clk);
    chk_idle("stray.during");
    @(posedge clk); #1 stray = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_idle($sformatf("stray.after%0d", c));
    end

    // Reset during WAIT of a req0 read
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 32'h40, '0);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 5) begin
        rst = 1'b1;
        bus.req0_enable_i = 1'b0;
      end
    end
    @(negedge clk);
    chk_idle("rstw");
    chk("rstw.data0", bus.req0_data_o, 0);
    chk("rstw.data1", bus.req1_data_o, 0);
`ifdef ARB_PERF_CNT_EN
    chk("rstw.perf_g0", bus.perf_grant0_o, 0);
    chk("rstw.perf_g1", bus.perf_grant1_o, 0);
    chk("rstw.perf_conf", bus.perf_conflict_o, 0);
    chk("rstw.perf_w0", bus.perf_wait0_o, 0);
    chk("rstw.perf_w1", bus.perf_wait1_o, 0);
`endif
    rst = 1'b0;
    saw_ack = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.req0_ack_o || bus.req1_ack_o || bus.mem_enable_o) saw_ack = 1'b1;
    end
    chk("rstw.no_late_activity", saw_ack, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter in front of the shared line-based data memory (256-bit lines, enable/write/ack handshake, fixed multi-cycle latency). Requester 0 is the L1 data cache and requester 1 is the L1 instruction cache; both see a memory-like port. Round-robin grant, one transaction in flight, a one-cycle enable pulse toward memory, and ack/data returned only to the owner.

Parameters:
ADDR_W, 32, address width on all ports
DATA_W, 256, line width on all data ports
CNT_W, 16, performance counter width (used only with ARB_PERF_CNT_EN)

Ports:
clk_i  in  1  clock; single clock domain
rst_i  in  1  reset, synchronous, active-high
req0_enable_i / req1_enable_i  in  1  request valid; held until ack
req0_write_i / req1_write_i  in  1  1=write line, 0=read line
req0_addr_i / req1_addr_i  in  ADDR_W  byte address, forwarded unmodified
req0_data_i / req1_data_i  in  DATA_W  write line
req0_ack_o / req1_ack_o  out  1  one-cycle completion pulse
req0_data_o / req1_data_o  out  DATA_W  read line, valid with ack and held afterwards
mem_enable_o  out  1  one-cycle issue pulse to memory
mem_write_o  out  1  owner's write bit
mem_addr_o  out  ADDR_W  owner's address
mem_data_o  out  DATA_W  owner's write line
mem_ack_i  in  1  memory completion
mem_data_i  in  DATA_W  memory read line; valid from the cycle after mem_ack_i

Behaviour:
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Registers: state, owner (1b), last_grant (1b), hold0/hold1 (DATA_W).
- IDLE: if any enable is high, choose owner and go to ISSUE. Both high: grant !last_grant. Only one high: grant that one. Update last_grant on grant.
- ISSUE: mem_enable_o=1 for exactly this cycle, then go to WAIT.
- WAIT: stay until mem_ack_i=1, then go to RESP. mem_ack_i is ignored in every other state.
- RESP: owner's ack_o=1. Owner's data_o = mem_data_i (pass-through). holdN captures mem_data_i at the end of RESP. Go to IDLE.
- Outside RESP, reqN_data_o = holdN. For writes, holdN is still updated; value don't-care.
- mem_write_o, mem_addr_o and mem_data_o are a combinational mux by owner from ISSUE through WAIT. In IDLE they are 0.
- Requester contract: hold enable/write/addr/data stable until ack. Drop enable no later than the edge after ack. Enable still high in the IDLE cycle after RESP counts as a new request.
- Latency: with the 7-cycle-wait memory, a request seen in cycle 0 gets ack in cycle 9. No back-to-back overlap. The minimum gap between transactions is one IDLE cycle.
- Non-owner requests wait and are never dropped.
- Reset: state=IDLE, owner=0, last_grant=1 (requester 0 wins first), hold0/hold1=0. All ack_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o = 0.
- Reset mid-transaction: abort to IDLE, with no ack to either requester. The system also resets memory; a stray mem_ack_i afterwards is ignored in IDLE.

Optional Feature:
ARB_PERF_CNT_EN. When defined, these CNT_W-bit outputs are added:
- perf_grant0_o, perf_grant1_o: increment on each grant to that requester.
- perf_conflict_o: increments in each IDLE cycle where both enables are high.
- perf_wait0_o, perf_wait1_o: increment in each cycle where that requester's enable is high but it is not the owner in RESP.
All counters saturate at all-ones and reset to 0.
When not defined, the ports and logic are absent and the arbitration behaviour is identical.

Decomposition:
- Package dmem_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), requester-ID constants REQ_DCACHE=0 and REQ_ICACHE=1, default ADDR_W/DATA_W.
- Sub-module rr_pick2: combinational 2-way round-robin select from enables and last_grant. Counters stay inline.

Test Plan:
- Single read: req0 read addr 0x40 in cycle 0, memory preloaded with line A at 0x40. mem_enable_o pulses only in cycle 1; req0_ack_o=1 only in cycle 9 with req0_data_o=A; req0_data_o stays A afterwards; req1_ack_o stays 0.
- Write then read: req1 writes line B to 0x80, then reads 0x80. The read returns B; mem_write_o=1 during the first transaction only.
- Simultaneous after reset: both enables rise in cycle 0. req0 is granted first (ack in cycle 9). req1's ISSUE falls in cycle 11 and its ack in cycle 19.
- Sustained contention: both requesters hold enable for 6 transactions. Grants strictly alternate 0,1,0,1,0,1; no starvation.
- Stray ack: pulse mem_ack_i in IDLE. No state change, and no ack_o on either requester.
- Reset mid-WAIT: assert rst_i in cycle 5 of a req0 read. Next cycle is IDLE with all outputs 0; no ack is ever produced for the aborted request. With ARB_PERF_CNT_EN defined, the counters read 0.
